// File: rtl/booth_multiplier_if.sv
// rtl/booth_multiplier_if.sv - request/response bundle for booth_multiplier
//
// Purpose: groups the operation request and product response of the
// multiplier into one port.
// Signals:
//   start        request, sampled only while done=1
//   signed_mode  1 = both operands two's complement, 0 = both unsigned
//   abort        synchronous cancel of an operation in progress
//   multiplier   operand X, bit 0 is MSB
//   multiplicand operand Y (Booth-recoded), bit 0 is MSB
//   result       double-width product, bit 0 is MSB
//   done         1 = idle and result valid
// Modports: master drives the request, slave is the multiplier.
interface booth_multiplier_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 signed_mode;
  logic                 abort;
  logic [0:WIDTH-1]     multiplier;
  logic [0:WIDTH-1]     multiplicand;
  logic [0:2*WIDTH-1]   result;
  logic                 done;

  modport master (
    output start, signed_mode, abort, multiplier, multiplicand,
    input  result, done
  );

  modport slave (
    input  start, signed_mode, abort, multiplier, multiplicand,
    output result, done
  );
endinterface

// File: rtl/booth_multiplier.sv
// rtl/booth_multiplier.sv - radix-4 iterative signed/unsigned multiplier
//
// Purpose: computes the full 2*WIDTH-bit product X*Y in WIDTH/2+2 cycles
// after the accepting edge, independent of operand values and mode.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    booth_multiplier_if slave (start/signed_mode/abort/operands in,
//          result/done out)
module booth_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic clock,
  input  logic reset,
  booth_multiplier_if.slave bus
);
  localparam int EW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH / 2 + 1);

  typedef enum logic [1:0] {IDLE, ITER, FINISH} state_t;

  state_t state, state_next;

  logic [EW-1:0]      acc_hi;
  logic [EW-1:0]      acc_lo;
  logic [EW-1:0]      x_ext;
  logic               bc;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] result_r;
  logic               done_r;

  logic [WIDTH-1:0]   mul_v;
  logic [WIDTH-1:0]   mcand_v;
  logic               accept;

  logic [2:0]         pair;
  logic [EW:0]        addend;
  logic               cs;
  logic [EW:0]        sum;
  logic               bc_next;

  assign mul_v      = bus.multiplier;
  assign mcand_v    = bus.multiplicand;
  assign bus.result = result_r;
  assign bus.done   = done_r;

  assign accept = (state == IDLE) && bus.start && !bus.abort;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ITER;
      ITER: begin
        if (bus.abort)        state_next = IDLE;
        else if (count == '0) state_next = FINISH;
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One Booth step. The sum carries one guard bit beyond the extended
  // operand width: A+2X can exceed the WIDTH+2 signed range, and the
  // arithmetic shift must fill from the true sign of that sum.
  always_comb begin
    pair    = {1'b0, acc_lo[1:0]} + {2'b00, bc};
    addend  = '0;
    cs      = 1'b0;
    case (pair[1:0])
      2'd0: addend = '0;
      2'd1: addend = {x_ext[EW-1], x_ext};
      2'd2: addend = {x_ext, 1'b0};
      2'd3: begin
        addend = ~{x_ext[EW-1], x_ext};
        cs     = 1'b1;
      end
      default: addend = '0;
    endcase
    // Digit 3 is recoded as -1 with a carry into the next pair, and a
    // pair sum of 4 is digit 0 with the same carry.
    bc_next = pair[2] | (pair[1:0] == 2'd3);
    sum     = {acc_hi[EW-1], acc_hi} + addend + {{EW{1'b0}}, cs};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_hi   <= '0;
      acc_lo   <= '0;
      x_ext    <= '0;
      bc       <= 1'b0;
      count    <= '0;
      result_r <= '0;
      done_r   <= 1'b1;
    end else begin
      done_r <= (state_next == IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            x_ext  <= bus.signed_mode ? {{2{mul_v[WIDTH-1]}}, mul_v}
                                      : {2'b00, mul_v};
            acc_lo <= bus.signed_mode ? {{2{mcand_v[WIDTH-1]}}, mcand_v}
                                      : {2'b00, mcand_v};
            acc_hi <= '0;
            bc     <= 1'b0;
            count  <= CW'(WIDTH / 2);
          end
        end
        ITER: begin
          acc_hi <= {sum[EW], sum[EW:2]};
          acc_lo <= {sum[1:0], acc_lo[EW-1:2]};
          bc     <= bc_next;
          count  <= count - CW'(1);
        end
        FINISH: begin
          // The abort also covers this cycle: the product is dropped.
          if (!bus.abort) result_r <= {acc_hi[WIDTH-3:0], acc_lo};
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_multiplier.sv
// tb/tb_booth_multiplier.sv - scoreboard bench for booth_multiplier
module tb_booth_multiplier;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  booth_multiplier_if #(.WIDTH(32)) b32 ();
  booth_multiplier_if #(.WIDTH(8))  b8 ();

  booth_multiplier #(.WIDTH(32)) dut32 (.clock(clock), .reset(reset), .bus(b32.slave));
  booth_multiplier #(.WIDTH(8))  dut8  (.clock(clock), .reset(reset), .bus(b8.slave));

  typedef struct {
    logic [63:0] exp;
    int          acc;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic sm);
    longint sa, sb;
    if (sm) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  function automatic logic [63:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic sm);
    int p;
    if (sm) p = int'($signed(a)) * int'($signed(b));
    else    p = int'(a) * int'(b);
    return {48'b0, 16'(p)};
  endfunction

  // Monitors: pop on each rising done and check product and latency.
  logic pd32 = 1'b1;
  logic pd8  = 1'b1;
  exp_t e32, e8;
  logic [63:0] r32, r8;

  always @(negedge clock) begin
    if (b32.done && !pd32 && q32.size() > 0) begin
      e32 = q32.pop_front();
      r32 = b32.result;
      chk("prod32", r32, e32.exp);
      chk("lat32", 64'(cyc - e32.acc), 64'd18);
    end
    pd32 <= b32.done;
  end

  always @(negedge clock) begin
    if (b8.done && !pd8 && q8.size() > 0) begin
      e8 = q8.pop_front();
      r8 = {48'b0, b8.result};
      chk("prod8", r8, e8.exp);
      chk("lat8", 64'(cyc - e8.acc), 64'd6);
    end
    pd8 <= b8.done;
  end

  task automatic wait_idle32();
    int n = 0;
    @(negedge clock);
    while (!b32.done && n < 100) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic sm,
                         input logic [63:0] exp);
    exp_t e;
    wait_idle32();
    chk("idle32", {63'b0, b32.done}, 64'd1);
    b32.multiplier   = a;
    b32.multiplicand = b;
    b32.signed_mode  = sm;
    b32.start        = 1'b1;
    e.exp = exp;
    e.acc = cyc + 1;
    q32.push_back(e);
    @(negedge clock);
    b32.start        = 1'b0;
    b32.multiplier   = $urandom;
    b32.multiplicand = $urandom;
    b32.signed_mode  = 1'($urandom);
  endtask

  task automatic drain32();
    int n = 0;
    while (q32.size() > 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("drain32", 64'(q32.size()), 64'd0);
  endtask

  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic sm,
                      input logic [63:0] exp);
    issue32(a, b, sm, exp);
    drain32();
  endtask

  // Stream n random width-8 products; while busy, start is either held
  // high or toggled randomly and operands churn, all of which must be ignored.
  task automatic run8(input int n, input bit hold);
    int issued = 0;
    int guard = 0;
    logic [7:0] a, b;
    logic sm;
    exp_t e;
    while ((issued < n || q8.size() > 0) && guard < n * 10 + 50) begin
      @(negedge clock);
      guard++;
      if (b8.done && issued < n) begin
        a  = 8'($urandom);
        b  = 8'($urandom);
        sm = 1'($urandom);
        b8.multiplier   = a;
        b8.multiplicand = b;
        b8.signed_mode  = sm;
        b8.start        = 1'b1;
        e.exp = ref8(a, b, sm);
        e.acc = cyc + 1;
        q8.push_back(e);
        issued++;
      end else if (b8.done) begin
        b8.start = 1'b0;
      end else begin
        b8.start        = hold ? 1'b1 : 1'($urandom);
        b8.multiplier   = 8'($urandom);
        b8.multiplicand = 8'($urandom);
        b8.signed_mode  = 1'($urandom);
      end
    end
    b8.start = 1'b0;
    chk("drain8", 64'(q8.size()), 64'd0);
  endtask

  task automatic spot8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                       input logic [15:0] exp);
    exp_t e;
    int n = 0;
    @(negedge clock);
    while (!b8.done && n < 50) begin
      @(negedge clock);
      n++;
    end
    b8.multiplier   = a;
    b8.multiplicand = b;
    b8.signed_mode  = sm;
    b8.start        = 1'b1;
    e.exp = {48'b0, exp};
    e.acc = cyc + 1;
    q8.push_back(e);
    @(negedge clock);
    b8.start = 1'b0;
    n = 0;
    while (q8.size() > 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("spot8_drain", 64'(q8.size()), 64'd0);
  endtask

  logic [31:0] ra, rb;
  logic        rsm;
  logic [63:0] rd;

  initial begin
    b32.start = 1'b0; b32.abort = 1'b0; b32.signed_mode = 1'b0;
    b32.multiplier = '0; b32.multiplicand = '0;
    b8.start = 1'b0; b8.abort = 1'b0; b8.signed_mode = 1'b0;
    b8.multiplier = '0; b8.multiplicand = '0;

    repeat (2) @(negedge clock);
    chk("rst_done32", {63'b0, b32.done}, 64'd1);
    chk("rst_result32", b32.result, 64'd0);
    chk("rst_done8", {63'b0, b8.done}, 64'd1);
    chk("rst_result8", {48'b0, b8.result}, 64'd0);
    reset = 1'b0;

    // Unsigned directed products.
    op32(32'd1, 32'd1, 1'b0, 64'd1);
    op32(32'd1, 32'd3, 1'b0, 64'd3);
    op32(32'd35, 32'd63, 1'b0, 64'd2205);
    op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001);

    // Signed directed products.
    op32(32'd35, 32'hFFFFFFEF, 1'b1, 64'hFFFFFFFFFFFFFDAD);
    op32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001);
    op32(32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000);
    op32(32'h7FFFFFFF, 32'h80000000, 1'b1, 64'hC000000080000000);

    // Start pulsed while busy must not disturb the product or latency.
    issue32(32'd1234, 32'd5678, 1'b0, 64'd7006652);
    repeat (3) @(negedge clock);
    b32.multiplier = 32'd99; b32.multiplicand = 32'd99; b32.start = 1'b1;
    @(negedge clock);
    b32.start = 1'b0;
    drain32();

    // Random width-32 products, with extreme operands mixed in.
    for (int i = 0; i < 150; i++) begin
      ra  = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      rsm = 1'($urandom);
      op32(ra, rb, rsm, ref32(ra, rb, rsm));
    end

    // Abort sequence.
    op32(32'd5, 32'd7, 1'b0, 64'd35);
    wait_idle32();
    b32.multiplier = 32'd9; b32.multiplicand = 32'd9; b32.signed_mode = 1'b0;
    b32.start = 1'b1;
    @(negedge clock);
    b32.start = 1'b0;
    repeat (3) @(negedge clock);
    chk("abort_busy", {63'b0, b32.done}, 64'd0);
    b32.abort = 1'b1;
    @(negedge clock);
    b32.abort = 1'b0;
    chk("abort_done", {63'b0, b32.done}, 64'd1);
    chk("abort_result", b32.result, 64'd35);
    b32.multiplier = 32'd4; b32.multiplicand = 32'd4;
    b32.start = 1'b1; b32.abort = 1'b1;
    @(negedge clock);
    b32.start = 1'b0; b32.abort = 1'b0;
    chk("abort_idle_done", {63'b0, b32.done}, 64'd1);
    chk("abort_idle_result", b32.result, 64'd35);
    op32(32'd9, 32'd9, 1'b0, 64'd81);

    // Asynchronous reset in the middle of ITER.
    issue32(32'd1000, 32'd1000, 1'b0, 64'd1000000);
    repeat (5) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("areset_done", {63'b0, b32.done}, 64'd1);
    chk("areset_result", b32.result, 64'd0);
    q32.delete();
    @(negedge clock);
    reset = 1'b0;
    op32(32'd2, 32'd3, 1'b0, 64'd6);

    // Width-8 spot checks and random streams.
    spot8(8'hFF, 8'hFF, 1'b0, 16'hFE01);
    spot8(8'hFF, 8'hFF, 1'b1, 16'h0001);
    spot8(8'h80, 8'h80, 1'b1, 16'h4000);
    spot8(8'h7F, 8'h80, 1'b1, 16'hC080);
    run8(1500, 1'b0);
    run8(500, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
